spectrum_peak_find: RTL and testbench
=====================================

// Module: spectrum_peak_find
// PURPOSE
//  Downstream of data_modulus: after the FFT magnitude frame is written to RAM (wr_done pulse),
//  scans the magnitude RAM and finds the two strongest spectral peaks of the two-tone mix.
//  Reports bin index and magnitude of each for the waveform/frequency separation logic.
//  Results are held stable between scans; a done pulse marks each new result set.
// PARAMETERS
//  ADDR_W    8    magnitude RAM address width (bin index width)
//  DATA_W    33   magnitude word width (matches data_modulus output)
//  SKIP      2    first bin read; bins below SKIP (DC leakage) never examined
//  SCAN_END  128  one past last bin read (N/2 for real input); SCAN_END > SKIP+2
//  RD_LAT    1    RAM read latency in cycles (rd_en/rd_addr to rd_data)
//  THRESH    0    candidate magnitude must be strictly greater than THRESH
// PORTS
//  clk        in   1       clock (same domain as data_modulus / RAM read port)
//  rst        in   1       synchronous reset, active-high
//  start      in   1       1-cycle pulse, driven by wr_done
//  rd_en      out  1       RAM read enable
//  rd_addr    out  ADDR_W  RAM read address
//  rd_data    in   DATA_W  RAM read data, valid RD_LAT cycles after rd_en
//  busy       out  1       high from cycle after accepted start through done cycle
//  done       out  1       1-cycle pulse, result outputs updated on the same edge
//  peak_cnt   out  2       number of peaks found: 0, 1 or 2
//  peak1_bin  out  ADDR_W  bin of largest peak (0 if none)
//  peak1_mag  out  DATA_W  magnitude of largest peak (0 if none)
//  peak2_bin  out  ADDR_W  bin of second peak (0 if cnt<2)
//  peak2_mag  out  DATA_W  magnitude of second peak (0 if cnt<2)
// BEHAVIOUR
//  Reset: all outputs 0, FSM to IDLE, in-flight reads/candidates discarded, no done issued.
//  FSM: IDLE -(start)-> READ -(last addr issued)-> DRAIN -(RD_LAT cycles)-> EVAL -> DONE -> IDLE.
//  start accepted only in IDLE; start while busy is ignored (no restart, no queueing).
//  Timing: start sampled at edge T0; rd_en=1 for cycles T1..TN, N=SCAN_END-SKIP, rd_addr=SKIP..SCAN_END-1
//   ascending, one per cycle; done at T(N+RD_LAT+2) (129 for defaults); busy T1..done incl.
//  Window: 3-sample shift register (prev,cur,next) of returned data with cur's bin index.
//  Bin k is a candidate iff SKIP<k<SCAN_END-1, m[k]>m[k-1], m[k]>=m[k+1], m[k]>THRESH.
//   Edge bins SKIP and SCAN_END-1 are never candidates. Plateau reports its first bin only.
//  Top-2 update (internal working regs, cleared at accepted start):
//   m>w1: w2<=w1, w1<=new; else m>w2: w2<=new. Strict compare: equal magnitudes keep lower bin first.
//  Working count saturates at 2. At DONE edge: outputs <= working regs; unfilled slots output 0.
//  Outputs never change during a scan; they change only on done or rst.
//  Magnitude compares unsigned, full DATA_W; no truncation.
// TESTING
//  1 all bins 10, m[10]=5000, m[40]=3000, pulse start -> done at T0+129, cnt=2, p1=(10,5000), p2=(40,3000).
//  2 flat spectrum all 100 -> done, cnt=0, all peak outputs 0.
//  3 m[20]=m[60]=4000, rest 0 -> cnt=2, p1_bin=20, p2_bin=60, both mags 4000.
//  4 m[1]=1000000, m[127]=900000, m[30]=500, rest 0 -> cnt=1, p1=(30,500); DC/edge bins ignored.
//  5 plateau m[50]=m[51]=800 plus m[90]=300 -> p1_bin=50, p2_bin=90; bin 51 not reported.
//  6 second start at T0+20 ignored (done once, T0+129); new start + rst at T0+50 -> no done, outputs 0, next start scans normally.

Source files
------------

// File: rtl/spectrum_peak_find.sv
// Scans a magnitude RAM after each frame write and reports the two strongest local peaks.
// Results are held between scans and are updated on the single-cycle done pulse.
module spectrum_peak_find #(
   parameter int ADDR_W   = 8,
   parameter int DATA_W   = 33,
   parameter int SKIP     = 2,
   parameter int SCAN_END = 128,
   parameter int RD_LAT   = 1,
   parameter int THRESH   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        peak_cnt,
   output logic [ADDR_W-1:0] peak1_bin,
   output logic [DATA_W-1:0] peak1_mag,
   output logic [ADDR_W-1:0] peak2_bin,
   output logic [DATA_W-1:0] peak2_mag
);

   localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(SKIP);
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(SCAN_END - 1);
   localparam logic [DATA_W-1:0] THR   = DATA_W'(THRESH);
   localparam int                DW    = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

   typedef enum logic [2:0] {IDLE, READ, DRAIN, EVAL, DONE} state_t;

   state_t            state, state_nxt;
   logic [DW-1:0]     drain_cnt;

   logic [RD_LAT-1:0] vld_pipe;
   logic [ADDR_W-1:0] bin_pipe [RD_LAT];
   logic              vld_p0;
   logic [ADDR_W-1:0] bin_p0;

   logic [DATA_W-1:0] prev_p1, cur_p1;
   logic [ADDR_W-1:0] cur_bin_p1;
   logic [1:0]        fill_p1;
   logic              peak_hit;

   logic [DATA_W-1:0] w1_mag, w2_mag;
   logic [ADDR_W-1:0] w1_bin, w2_bin;
   logic [1:0]        w_cnt;

   function automatic logic [1:0] sat_inc(input logic [1:0] c);
      return (c == 2'd2) ? c : c + 2'd1;
   endfunction

   // Edge bins lack a neighbour on one side; plateaus report only their first bin.
   function automatic logic is_peak(input logic [DATA_W-1:0] prv,
                                    input logic [DATA_W-1:0] cur,
                                    input logic [DATA_W-1:0] nxt,
                                    input logic [ADDR_W-1:0] bin);
      return (bin > FIRST) && (bin < LAST) && (cur > prv) && (cur >= nxt) && (cur > THR);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = READ;
         READ:    if (rd_addr == LAST) state_nxt = DRAIN;
         DRAIN:   if (drain_cnt == DW'(RD_LAT - 1)) state_nxt = EVAL;
         EVAL:    state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign rd_en    = (state == READ);
   assign busy     = (state != IDLE);
   assign vld_p0   = vld_pipe[RD_LAT-1];
   assign bin_p0   = bin_pipe[RD_LAT-1];
   assign peak_hit = vld_p0 && (fill_p1 == 2'd2) && is_peak(prev_p1, cur_p1, rd_data, cur_bin_p1);

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_addr   <= '0;
         drain_cnt <= '0;
         vld_pipe  <= '0;
         fill_p1   <= '0;
         w_cnt     <= '0;
         done      <= 1'b0;
         peak_cnt  <= '0;
         peak1_bin <= '0;
         peak1_mag <= '0;
         peak2_bin <= '0;
         peak2_mag <= '0;
      end else begin
         done <= (state == EVAL);
         case (state)
            IDLE: begin
               if (start) begin
                  rd_addr <= FIRST;
                  fill_p1 <= '0;
                  w_cnt   <= '0;
               end
            end
            READ: begin
               if (rd_addr != LAST) rd_addr <= rd_addr + 1'b1;
               drain_cnt <= '0;
            end
            DRAIN: drain_cnt <= drain_cnt + 1'b1;
            EVAL: begin
               peak_cnt  <= w_cnt;
               peak1_bin <= w1_bin;
               peak1_mag <= w1_mag;
               peak2_bin <= w2_bin;
               peak2_mag <= w2_mag;
            end
            default: ;
         endcase
         vld_pipe[0] <= rd_en;
         for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
         if (vld_p0 && (fill_p1 != 2'd2)) fill_p1 <= fill_p1 + 2'd1;
         if (peak_hit) w_cnt <= sat_inc(w_cnt);
      end
   end

   // p0: returned RAM word tagged with its bin; p1: window shift and top-2 update
   always_ff @(posedge clk) begin
      bin_pipe[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) bin_pipe[i] <= bin_pipe[i-1];
      if (vld_p0) begin
         prev_p1    <= cur_p1;
         cur_p1     <= rd_data;
         cur_bin_p1 <= bin_p0;
      end
      if ((state == IDLE) && start) begin
         w1_mag <= '0;
         w1_bin <= '0;
         w2_mag <= '0;
         w2_bin <= '0;
      end else if (peak_hit) begin
         if (cur_p1 > w1_mag) begin
            w2_mag <= w1_mag;
            w2_bin <= w1_bin;
            w1_mag <= cur_p1;
            w1_bin <= cur_bin_p1;
         end else if (cur_p1 > w2_mag) begin
            w2_mag <= cur_p1;
            w2_bin <= cur_bin_p1;
         end
      end
   end

endmodule

// File: tb/tb_spectrum_peak_find.sv
// Randomised scoreboard bench for spectrum_peak_find with a behavioural RAM and
// a reference model that picks peaks from the whole frame array at once.
module tb_spectrum_peak_find;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 33;
   localparam int SKIP     = 2;
   localparam int SCAN_END = 128;
   localparam int RD_LAT   = 1;
   localparam int THRESH   = 0;
   localparam int NBINS    = SCAN_END - SKIP;
   localparam int LAT      = NBINS + RD_LAT + 2;

   typedef struct {
      int                cnt;
      logic [ADDR_W-1:0] b1;
      logic [DATA_W-1:0] m1;
      logic [ADDR_W-1:0] b2;
      logic [DATA_W-1:0] m2;
      longint            done_at;
   } exp_t;

   logic              clk;
   logic              rst;
   logic              start;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              busy;
   logic              done;
   logic [1:0]        peak_cnt;
   logic [ADDR_W-1:0] peak1_bin;
   logic [DATA_W-1:0] peak1_mag;
   logic [ADDR_W-1:0] peak2_bin;
   logic [DATA_W-1:0] peak2_mag;

   logic [DATA_W-1:0] mem [256];
   exp_t              sb [$];
   longint            cyc = 0;
   logic              rst_q = 1'b1;
   int                vectors = 0;
   int                miscompares = 0;
   int                exp_addr = SKIP;

   spectrum_peak_find #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SKIP(SKIP),
      .SCAN_END(SCAN_END), .RD_LAT(RD_LAT), .THRESH(THRESH)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .busy(busy), .done(done), .peak_cnt(peak_cnt),
      .peak1_bin(peak1_bin), .peak1_mag(peak1_mag),
      .peak2_bin(peak2_bin), .peak2_mag(peak2_mag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
      if (rd_en) rd_data <= mem[rd_addr];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Peaks are chosen from the complete frame: largest first, lowest bin on ties.
   function automatic exp_t ref_model();
      exp_t e;
      int   c [$];
      int   best;
      e.cnt = 0; e.b1 = '0; e.m1 = '0; e.b2 = '0; e.m2 = '0; e.done_at = 0;
      for (int k = SKIP + 1; k <= SCAN_END - 2; k++)
         if (mem[k] > mem[k-1] && mem[k] >= mem[k+1] && mem[k] > DATA_W'(THRESH))
            c.push_back(k);
      e.cnt = (c.size() > 2) ? 2 : c.size();
      for (int slot = 0; slot < 2 && c.size() > 0; slot++) begin
         best = 0;
         for (int i = 1; i < c.size(); i++)
            if (mem[c[i]] > mem[c[best]]) best = i;
         if (slot == 0) begin
            e.b1 = ADDR_W'(c[best]);
            e.m1 = mem[c[best]];
         end else begin
            e.b2 = ADDR_W'(c[best]);
            e.m2 = mem[c[best]];
         end
         c.delete(best);
      end
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_q) exp_addr = SKIP;
      else if (rd_en) begin
         check("rd_addr", 64'(rd_addr), 64'(exp_addr));
         exp_addr = (exp_addr == SCAN_END - 1) ? SKIP : exp_addr + 1;
      end
   end

   logic [1:0]        last_cnt = '0;
   logic [ADDR_W-1:0] last_b1 = '0, last_b2 = '0;
   logic [DATA_W-1:0] last_m1 = '0, last_m2 = '0;

   always @(negedge clk) begin
      exp_t e;
      if (rst_q) begin
         check("rst_done", 64'(done), 64'(0));
         check("rst_cnt", 64'(peak_cnt), 64'(0));
         check("rst_p1", 64'({peak1_bin, peak1_mag}), 64'(0));
         check("rst_p2", 64'({peak2_bin, peak2_mag}), 64'(0));
      end else if (done) begin
         if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_done: got done at edge %0d, expected none", cyc + 1);
         end else begin
            e = sb.pop_front();
            check("done_edge", 64'(cyc + 1), 64'(e.done_at));
            check("busy_at_done", 64'(busy), 64'(1));
            check("peak_cnt", 64'(peak_cnt), 64'(e.cnt));
            check("peak1_bin", 64'(peak1_bin), 64'(e.b1));
            check("peak1_mag", 64'(peak1_mag), 64'(e.m1));
            check("peak2_bin", 64'(peak2_bin), 64'(e.b2));
            check("peak2_mag", 64'(peak2_mag), 64'(e.m2));
         end
      end else begin
         check("hold_cnt", 64'(peak_cnt), 64'(last_cnt));
         check("hold_p1", 64'({peak1_bin, peak1_mag}), 64'({last_b1, last_m1}));
         check("hold_p2", 64'({peak2_bin, peak2_mag}), 64'({last_b2, last_m2}));
      end
      last_cnt = peak_cnt;
      last_b1  = peak1_bin;
      last_m1  = peak1_mag;
      last_b2  = peak2_bin;
      last_m2  = peak2_mag;
   end

   task automatic fill(input logic [DATA_W-1:0] v);
      for (int i = 0; i < 256; i++) mem[i] = v;
   endtask

   task automatic issue_start(input bit expect_done, output longint t0);
      exp_t e;
      @(negedge clk);
      t0 = cyc + 1;
      if (expect_done) begin
         e = ref_model();
         e.done_at = t0 + LAT;
         sb.push_back(e);
      end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int i = 0; i < LAT + 20 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         vectors++;
         miscompares++;
         $display("FAIL done_timeout: got no done, expected %0d pending result(s)", sb.size());
         sb.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic run_scan();
      longint t0;
      issue_start(1'b1, t0);
      wait_done();
   endtask

   initial begin
      longint t0;
      int     mode;
      rst   = 1'b1;
      start = 1'b0;
      fill('0);
      repeat (3) @(negedge clk);
      check("busy_rst", 64'(busy), 64'(0));
      check("rd_en_rst", 64'(rd_en), 64'(0));
      rst = 1'b0;

      fill(33'd10); mem[10] = 33'd5000; mem[40] = 33'd3000;
      run_scan();
      check("t1_cnt", 64'(peak_cnt), 64'(2));
      check("t1_p1", 64'({peak1_bin, peak1_mag}), 64'({8'd10, 33'd5000}));
      check("t1_p2", 64'({peak2_bin, peak2_mag}), 64'({8'd40, 33'd3000}));

      fill(33'd100);
      run_scan();
      check("t2_cnt", 64'(peak_cnt), 64'(0));
      check("t2_p1", 64'({peak1_bin, peak1_mag}), 64'(0));

      fill('0); mem[20] = 33'd4000; mem[60] = 33'd4000;
      run_scan();
      check("t3_bins", 64'({peak1_bin, peak2_bin}), 64'({8'd20, 8'd60}));

      fill('0); mem[1] = 33'd1000000; mem[127] = 33'd900000; mem[30] = 33'd500;
      run_scan();
      check("t4_cnt", 64'(peak_cnt), 64'(1));
      check("t4_p1", 64'({peak1_bin, peak1_mag}), 64'({8'd30, 33'd500}));

      fill('0); mem[50] = 33'd800; mem[51] = 33'd800; mem[90] = 33'd300;
      run_scan();
      check("t5_bins", 64'({peak1_bin, peak2_bin}), 64'({8'd50, 8'd90}));

      for (int s = 0; s < 10; s++) begin
         mode = s % 3;
         for (int i = 0; i < 256; i++) begin
            if (mode == 0)      mem[i] = {1'($urandom_range(0, 1)), 32'($urandom)};
            else if (mode == 1) mem[i] = DATA_W'($urandom_range(0, 3));
            else                mem[i] = ($urandom_range(0, 15) == 0) ? DATA_W'($urandom) : '0;
         end
         run_scan();
      end

      // A start while busy must not restart the scan.
      fill(33'd7); mem[33] = 33'd70000; mem[99] = 33'd60000; mem[100] = 33'd90000;
      issue_start(1'b1, t0);
      while (cyc < t0 + 19) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();

      // Reset mid-scan discards the scan; a later start scans normally.
      for (int i = 0; i < 256; i++) mem[i] = DATA_W'($urandom_range(0, 1000));
      issue_start(1'b0, t0);
      while (cyc < t0 + 49) @(negedge clk);
      start = 1'b1;
      rst   = 1'b1;
      @(negedge clk);
      start = 1'b0;
      rst   = 1'b0;
      repeat (LAT + 20) @(negedge clk);
      check("t6_busy", 64'(busy), 64'(0));
      check("t6_cnt", 64'(peak_cnt), 64'(0));
      check("t6_p1", 64'({peak1_bin, peak1_mag}), 64'(0));
      run_scan();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no end of test, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
